avm_pio_poller: RTL and testbench

- Avalon-MM read master that periodically polls a 4-bit PIO input slave (switch bank) at offset 0.
- Debounces the returned value and publishes a stable copy, plus a one-cycle change pulse, to downstream control logic.
- Sits on the system interconnect as an initiator, opposite the PIO responder.
- Tolerates interconnect waitrequest and variable read latency through readdatavalid.

---
 rtl/avm_pio_if.sv | 18 +
 rtl/avm_pio_poller.sv | 139 +++++++++++++
 tb/tb_avm_pio_poller.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/avm_pio_if.sv
// Avalon-MM read-only link between the switch-bank poller (master) and the PIO responder (slave).
interface avm_pio_if;
   logic [1:0]  address;
   logic        read;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        readdatavalid;

   modport master (
      output address, read,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/avm_pio_poller.sv
// Periodic Avalon-MM read poller for a 4-bit PIO switch bank; debounces the sampled value,
// publishes a stable copy with a one-cycle change pulse and flags response timeouts.
module avm_pio_poller #(
   parameter int unsigned DATA_W       = 4,
   parameter int unsigned POLL_PERIOD  = 50000,
   parameter int unsigned DEBOUNCE_CNT = 4,
   parameter int unsigned RESP_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   avm_pio_if.master         avm,
   output logic [DATA_W-1:0] stable_value,
   output logic              change_pulse,
   output logic              timeout_err,
   input  logic              clear_err
);

   localparam int unsigned TW = $clog2(POLL_PERIOD);
   localparam int unsigned RW = $clog2(RESP_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_PERIOD - 1);
   localparam logic [RW-1:0] RESP_LAST    = RW'(RESP_TIMEOUT - 1);
   localparam logic [3:0]    DEB          = 4'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, EVAL} state_t;

   state_t            state, state_nxt;
   logic [TW-1:0]     timer, timer_nxt;
   logic              read_q, read_nxt;
   logic [RW-1:0]     resp_cnt, resp_cnt_nxt;
   logic [DATA_W-1:0] sample, sample_nxt;
   logic [DATA_W-1:0] candidate, candidate_nxt;
   logic [DATA_W-1:0] stable_nxt;
   logic [3:0]        match_cnt, match_nxt;
   logic              pulse_nxt;
   logic              timeout_hit;
   logic              unused_rdata;

   assign avm.address  = '0;
   assign avm.read     = read_q;
   assign unused_rdata = ^avm.readdata[31:DATA_W];

   always_comb begin
      state_nxt     = state;
      timer_nxt     = timer;
      read_nxt      = read_q;
      resp_cnt_nxt  = resp_cnt;
      sample_nxt    = sample;
      candidate_nxt = candidate;
      match_nxt     = match_cnt;
      stable_nxt    = stable_value;
      pulse_nxt     = 1'b0;
      timeout_hit   = 1'b0;

      // The period timer keeps running through a transaction so reads stay on a fixed grid;
      // it saturates at zero if a transaction overruns the period.
      if (!enable)
         timer_nxt = TIMER_RELOAD;
      else if (timer != '0)
         timer_nxt = timer - TW'(1);

      case (state)
         IDLE: begin
            if (enable && timer == '0) begin
               state_nxt = REQ;
               read_nxt  = 1'b1;
               timer_nxt = TIMER_RELOAD;
            end
         end
         REQ: begin
            resp_cnt_nxt = '0;
            if (!avm.waitrequest) begin
               read_nxt = 1'b0;
               if (avm.readdatavalid) begin
                  sample_nxt = avm.readdata[DATA_W-1:0];
                  state_nxt  = EVAL;
               end else begin
                  state_nxt = WAIT_DATA;
               end
            end
         end
         WAIT_DATA: begin
            if (avm.readdatavalid) begin
               sample_nxt = avm.readdata[DATA_W-1:0];
               state_nxt  = EVAL;
            end else if (resp_cnt == RESP_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end else begin
               resp_cnt_nxt = resp_cnt + RW'(1);
            end
         end
         EVAL: begin
            if (sample == candidate) begin
               match_nxt = (match_cnt >= DEB) ? DEB : match_cnt + 4'd1;
            end else begin
               candidate_nxt = sample;
               match_nxt     = 4'd1;
            end
            if (match_nxt == DEB && candidate_nxt != stable_value) begin
               stable_nxt = candidate_nxt;
               pulse_nxt  = 1'b1;
            end
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         timer        <= TIMER_RELOAD;
         read_q       <= 1'b0;
         resp_cnt     <= '0;
         sample       <= '0;
         candidate    <= '0;
         match_cnt    <= '0;
         stable_value <= '0;
         change_pulse <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state        <= state_nxt;
         timer        <= timer_nxt;
         read_q       <= read_nxt;
         resp_cnt     <= resp_cnt_nxt;
         sample       <= sample_nxt;
         candidate    <= candidate_nxt;
         match_cnt    <= match_nxt;
         stable_value <= stable_nxt;
         change_pulse <= pulse_nxt;
         if (timeout_hit)
            timeout_err <= 1'b1;
         else if (clear_err)
            timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_avm_pio_poller.sv
// Directed bench for avm_pio_poller: behavioural PIO slave with configurable stall/latency,
// hand-computed expectations for polling cadence, debounce, timeout, enable and reset handling.
module tb_avm_pio_poller;

   localparam int unsigned PP = 8;
   localparam int unsigned DB = 4;
   localparam int unsigned RT = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       clear_err;
   logic [3:0] stable_value;
   logic       change_pulse;
   logic       timeout_err;

   avm_pio_if avm();

   avm_pio_poller #(
      .DATA_W(4), .POLL_PERIOD(PP), .DEBOUNCE_CNT(DB), .RESP_TIMEOUT(RT)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .avm(avm),
      .stable_value(stable_value), .change_pulse(change_pulse),
      .timeout_err(timeout_err), .clear_err(clear_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int req_q[$];
   int rdv_n = 0, accepts = 0, pulse_cnt = 0;
   int last_pulse_cyc = 0, last_rdv_cyc = 0;
   int run_len = 0, last_run_len = 0;
   bit addr_bad = 1'b0, prev_read = 1'b0;
   logic [3:0] resp_data;
   int lat = 1, ws_cfg = 0, ws_left = 0, pend = 0;
   bit no_resp = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive_resp();
      avm.readdatavalid = 1'b1;
      avm.readdata      = {28'hA5C3F0E, resp_data};
      rdv_n++;
      last_rdv_cyc = cyc;
   endtask

   // One clock: sample DUT outputs on the falling edge, then drive slave inputs for the next rise.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (avm.read === 1'b1) begin
         run_len++;
         if (avm.address !== 2'b00) addr_bad = 1'b1;
         if (!prev_read) req_q.push_back(cyc);
      end else if (prev_read) begin
         last_run_len = run_len;
         run_len = 0;
      end
      prev_read = (avm.read === 1'b1);
      if (change_pulse === 1'b1) begin
         pulse_cnt++;
         last_pulse_cyc = cyc;
      end

      avm.readdatavalid = 1'b0;
      avm.waitrequest   = 1'b0;
      avm.readdata      = 32'h5A5A5A50;
      if (pend > 0) begin
         pend--;
         if (pend == 0) drive_resp();
      end
      if (avm.read === 1'b1) begin
         if (ws_left > 0) begin
            avm.waitrequest = 1'b1;
            ws_left--;
         end else begin
            accepts++;
            if (!no_resp) begin
               if (lat == 0) drive_resp();
               else pend = lat;
            end
         end
      end else begin
         ws_left = ws_cfg;
      end
   endtask

   task automatic wait_req(output int start);
      int n0;
      n0 = req_q.size();
      for (int i = 0; i < 64 && req_q.size() == n0; i++) step();
      check("req_seen", 32'(req_q.size() > n0), 32'd1);
      start = (req_q.size() > n0) ? req_q[$] : cyc;
   endtask

   task automatic wait_resp(input int n);
      int r0;
      r0 = rdv_n;
      for (int i = 0; i < 40 * n && (rdv_n - r0) < n; i++) step();
      check("resp_seen", rdv_n - r0, n);
   endtask

   initial begin
      int rel, s, s2, s3, s4, s5, s6, s7, e, a0, pc, nreq;
      logic [3:0] bounce_v [6];
      logic [3:0] bounce_e [6];
      logic [3:0] post_rst_e [4];

      bounce_v = '{4'hA, 4'h5, 4'hA, 4'hA, 4'hA, 4'hA};
      bounce_e = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'hA};
      post_rst_e = '{4'h0, 4'h0, 4'h0, 4'hC};

      reset = 1'b1; enable = 1'b1; clear_err = 1'b0;
      resp_data = 4'h5;
      avm.waitrequest = 1'b0; avm.readdatavalid = 1'b0; avm.readdata = '0;

      repeat (3) step();
      check("rst_read",   32'(avm.read), 32'd0);
      check("rst_addr",   32'(avm.address), 32'd0);
      check("rst_stable", 32'(stable_value), 32'd0);
      check("rst_pulse",  32'(change_pulse), 32'd0);
      check("rst_err",    32'(timeout_err), 32'd0);

      // Basic polling: value 0x5, latency 1, no stalls.
      reset = 1'b0;
      rel = cyc;
      wait_resp(4);
      check("first_req_gap", req_q[0] - rel, PP);
      check("req_gap_1", req_q[1] - req_q[0], PP);
      check("req_gap_3", req_q[3] - req_q[2], PP);
      check("pre_stable", 32'(stable_value), 32'h0);
      step();
      check("eval_pulse", 32'(change_pulse), 32'd0);
      step();
      check("stable_5", 32'(stable_value), 32'h5);
      check("pulse_on", 32'(change_pulse), 32'd1);
      step();
      check("pulse_off", 32'(change_pulse), 32'd0);
      check("pulse_cnt_1", pulse_cnt, 1);

      // Bouncing input.
      pc = pulse_cnt;
      for (int i = 0; i < 6; i++) begin
         resp_data = bounce_v[i];
         wait_resp(1);
         step();
         step();
         check($sformatf("bounce_%0d", i), 32'(stable_value), 32'(bounce_e[i]));
      end
      check("bounce_pulses", pulse_cnt - pc, 1);

      // Five waitrequest cycles with a zero-latency slave.
      ws_cfg = 5; lat = 0; resp_data = 4'hA;
      a0 = accepts;
      wait_req(s);
      ws_cfg = 0;
      for (int i = 0; i < 20 && prev_read; i++) step();
      check("stall_read_len", last_run_len, 6);
      check("stall_addr", 32'(addr_bad), 32'd0);
      check("stall_accepts", accepts - a0, 1);
      wait_req(s2);
      check("stall_next_req", s2 - s, PP);

      // Response timeout.
      no_resp = 1'b1; lat = 1;
      wait_req(s3);
      for (int i = 0; i < 16; i++) step();
      check("err_before", 32'(timeout_err), 32'd0);
      step();
      check("err_set", 32'(timeout_err), 32'd1);
      check("err_stable", 32'(stable_value), 32'hA);
      no_resp = 1'b0;
      wait_req(s4);
      check("repoll", 32'((s4 > s3 + 17) && (s4 <= s3 + 17 + int'(PP))), 32'd1);
      check("err_sticky", 32'(timeout_err), 32'd1);
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      check("err_clear", 32'(timeout_err), 32'd0);

      // Drop enable while a read is in WAIT_DATA.
      resp_data = 4'h3;
      wait_resp(3);
      lat = 3;
      wait_req(s5);
      step();
      enable = 1'b0;
      pc = pulse_cnt;
      for (int i = 0; i < 20 && pulse_cnt == pc; i++) step();
      check("dis_pulse", pulse_cnt - pc, 1);
      check("dis_latency", last_pulse_cyc - last_rdv_cyc, 2);
      check("dis_stable", 32'(stable_value), 32'h3);
      nreq = req_q.size();
      repeat (30) step();
      check("dis_no_read", req_q.size() - nreq, 0);
      enable = 1'b1;
      e = cyc;
      wait_req(s6);
      check("reenable_gap", s6 - e, PP);

      // Reset during WAIT_DATA with a late response.
      lat = 4; resp_data = 4'hC;
      wait_req(s7);
      pc = pulse_cnt;
      step();
      reset = 1'b1;
      step();
      check("mid_rst_read",   32'(avm.read), 32'd0);
      check("mid_rst_stable", 32'(stable_value), 32'h0);
      check("mid_rst_err",    32'(timeout_err), 32'd0);
      step();
      reset = 1'b0;
      step();
      lat = 1;
      for (int i = 0; i < 4; i++) begin
         wait_resp(1);
         step();
         step();
         check($sformatf("post_rst_%0d", i), 32'(stable_value), 32'(post_rst_e[i]));
      end
      check("post_rst_pulses", pulse_cnt - pc, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
